// File: rtl/tia_divide_by_three.sv
// Divide-by-three phase clock generator for the TIA timing chain.
// phi_theta is high for one clk period out of every three and comes straight from a flop.
module tia_divide_by_three (
  input  logic clk,
  input  logic resphi0,
  output logic phi_theta
);

  // Phase counter encoding; PH_BAD is unreachable in normal operation but decoded for upset recovery.
  typedef enum logic [1:0] {
    PH_0   = 2'd0,
    PH_1   = 2'd1,
    PH_2   = 2'd2,
    PH_BAD = 2'd3
  } phase_e;

  phase_e cnt;
  phase_e cnt_next;

  // Next phase: count 0,1,2 and wrap; the illegal code folds back to 0 in one step.
  always_comb begin
    cnt_next = PH_0;
    case (cnt)
      PH_0:    cnt_next = PH_1;
      PH_1:    cnt_next = PH_2;
      default: cnt_next = PH_0;
    endcase
  end

  // Phase register and output flop; reset parks at PH_2 so the first edge after release pulses.
  always_ff @(posedge clk or negedge resphi0) begin
    if (!resphi0) begin
      cnt       <= PH_2;
      phi_theta <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      phi_theta <= (cnt_next == PH_0);
    end
  end

endmodule

// File: tb/tb_tia_divide_by_three.sv
// Directed bench for tia_divide_by_three with an expected-value queue per clk edge.
module tb_tia_divide_by_three;

  logic clk;
  logic resphi0;
  logic phi_theta;

  int checks = 0;
  int errors = 0;
  int since  = 0;     // edges seen since the last reset release
  int cyc    = 0;     // global edge index for period tracking
  int last_hi = -1;   // edge index of the previous high sample
  bit exp_q[$];

  tia_divide_by_three dut (
    .clk       (clk),
    .resphi0   (resphi0),
    .phi_theta (phi_theta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Push the expected output for each coming edge, then pop and compare after the edge.
  task automatic run_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back((since % 3) == 0);
      since++;
      @(posedge clk);
      #1;
      cyc++;
      check_bit(tag, phi_theta, exp_q.pop_front());
      if (phi_theta === 1'b1) begin
        if (last_hi >= 0) check_int({tag, "_period"}, cyc - last_hi, 3);
        last_hi = cyc;
      end
    end
  endtask

  task automatic assert_reset(input string tag);
    resphi0 = 1'b0;
    #1;
    check_bit(tag, phi_theta, 1'b0);
  endtask

  task automatic hold_reset(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_bit(tag, phi_theta, 1'b0);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    #2;
    resphi0 = 1'b1;
    since   = 0;
    last_hi = -1;
    exp_q.delete();
  endtask

  int k;

  initial begin
    resphi0 = 1'b0;
    #1;
    check_bit("reset_value", phi_theta, 1'b0);
    hold_reset(5, "powerup_reset");
    release_reset();
    run_cycles(3, "powerup");

    run_cycles(300, "steady");
    run_cycles(30, "duty");

    // Position so the last edge produced a pulse, then reset while high.
    k = ((3 - (since % 3)) % 3) + 1;
    run_cycles(k, "to_pulse");
    check_bit("pulse_is_high", phi_theta, 1'b1);
    assert_reset("async_drop_pulse");
    hold_reset(1, "pulse_reset_hold");
    release_reset();
    run_cycles(6, "after_pulse_reset");

    // Position at cnt == 1 (the edge after a pulse), hold reset for two clocks.
    k = (2 - (since % 3) + 3) % 3;
    if (k == 0) k = 3;
    run_cycles(k, "to_low");
    check_bit("low_is_low", phi_theta, 1'b0);
    assert_reset("mid_low_drop");
    hold_reset(2, "mid_low_hold");
    release_reset();
    run_cycles(9, "mid_low_resume");

    // Short glitch on reset while the output is high, between clk edges.
    k = ((3 - (since % 3)) % 3) + 1;
    run_cycles(k, "to_pulse2");
    @(negedge clk);
    #1;
    resphi0 = 1'b0;
    #1;
    resphi0 = 1'b1;
    #1;
    check_bit("glitch_reset", phi_theta, 1'b0);
    since   = 0;
    last_hi = -1;
    exp_q.delete();
    run_cycles(6, "glitch_realign");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
